// File: rtl/regfile_responder.sv
// regfile_responder: register file with one write port and in-order tagged read responses through a ready/valid FIFO
module regfile_responder #(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int RESP_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic                  rs_addr_sel,
  input  logic                  rs_addr_valid,
  output logic                  rs_addr_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [BUS_WIDTH-1:0]  rd_data,
  input  logic                  rd_we,
  output logic [BUS_WIDTH-1:0]  rs_data,
  output logic                  rs_data_sel,
  output logic                  rs_data_valid,
  input  logic                  rs_data_ready
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = PW + 1;
  logic [BUS_WIDTH-1:0]  regs [NUM_REGS];
  logic [BUS_WIDTH-1:0]  fifo_data [RESP_DEPTH];
  logic [RESP_DEPTH-1:0] fifo_sel;
  logic [PW-1:0]         wptr, rptr;
  logic [CW-1:0]         count;
  logic [BUS_WIDTH-1:0]  rdata;
  logic                  push, pop;
  assign rs_addr_ready = count != CW'(RESP_DEPTH);
  assign rs_data_valid = count != '0;
  assign push = rs_addr_valid && rs_addr_ready;
  assign pop = rs_data_valid && rs_data_ready;
  assign rs_data = fifo_data[rptr];
  assign rs_data_sel = fifo_sel[rptr];
  // write-first: a same-cycle write to the requested register is forwarded
  always_comb rdata = rs_addr == '0 ? '0 : (rd_we && rd_addr == rs_addr) ? rd_data : regs[rs_addr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (rd_we && rd_addr != '0) begin
      regs[rd_addr] <= rd_data;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < RESP_DEPTH; i++) fifo_data[i] <= '0;
      fifo_sel <= '0;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fifo_data[wptr] <= rdata;
        fifo_sel[wptr] <= rs_addr_sel;
        wptr <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: tb/tb_regfile_responder.sv
// tb_regfile_responder: randomized and directed traffic scored against a queue-based register-file model
module tb_regfile_responder;
  logic        clk = 0;
  logic        rst = 1;
  logic [4:0]  rs_addr = '0;
  logic        rs_addr_sel = 0;
  logic        rs_addr_valid = 0;
  logic        rs_addr_ready;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_data = '0;
  logic        rd_we = 0;
  logic [31:0] rs_data;
  logic        rs_data_sel;
  logic        rs_data_valid;
  logic        rs_data_ready = 0;

  regfile_responder dut (
    .clk(clk), .rst(rst),
    .rs_addr(rs_addr), .rs_addr_sel(rs_addr_sel), .rs_addr_valid(rs_addr_valid), .rs_addr_ready(rs_addr_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_we(rd_we),
    .rs_data(rs_data), .rs_data_sel(rs_data_sel), .rs_data_valid(rs_data_valid), .rs_data_ready(rs_data_ready)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [32:0] q[$];
  logic [31:0] mreg [32];
  bit          pend = 0;
  logic [32:0] pexp;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // one clock of stimulus: commit last cycle's accepted request, then drive this cycle
  task automatic cyc(input bit v, input logic [4:0] a, input bit s, input bit we,
                     input logic [4:0] wa, input logic [31:0] wd, input bit dr);
    @(posedge clk);
    if (pend) q.push_back(pexp);
    #1;
    rs_addr_valid = v; rs_addr = a; rs_addr_sel = s;
    rd_we = we; rd_addr = wa; rd_data = wd; rs_data_ready = dr;
    chk("rs_addr_ready", rs_addr_ready, q.size() < 2);
    pend = v && q.size() < 2;
    pexp = {(a == 0) ? 32'h0 : (we && wa == a) ? wd : mreg[a], s};
    if (we && wa != 0) mreg[wa] = wd;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1; rs_addr_valid = 0; rd_we = 0; pend = 0;
    #1;
    chk("valid_in_reset", rs_data_valid, 0);
    q.delete();
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    @(negedge clk);
    #2;
    rst = 0;
    chk("ready_after_reset", rs_addr_ready, 1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rs_data_valid", rs_data_valid, q.size() != 0);
        if (rs_data_valid && q.size() != 0) begin
          chk("rs_data", rs_data, q[0][32:1]);
          chk("rs_data_sel", rs_data_sel, q[0][0]);
          if (rs_data_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [4:0] a;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    #2;
    chk("reset_valid", rs_data_valid, 0);
    chk("reset_ready", rs_addr_ready, 1);
    chk("reset_data", rs_data, 0);
    chk("reset_sel", rs_data_sel, 0);
    #1 rst = 0;
    cyc(0, 0, 0, 1, 3, 32'hDEADBEEF, 1);
    cyc(1, 3, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 32'hFFFFFFFF, 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 7, 0, 1, 7, 32'h12345678, 1);
    cyc(1, 7, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1, 32'h11, 1);
    cyc(0, 0, 0, 1, 2, 32'h22, 1);
    cyc(0, 0, 0, 1, 3, 32'h33, 1);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 2, 1, 0, 0, 0, 0);
    cyc(1, 3, 0, 0, 0, 0, 0);
    cyc(1, 3, 0, 0, 0, 0, 0);
    cyc(1, 3, 0, 0, 0, 0, 1);
    cyc(1, 3, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 4, 32'hA, 1);
    cyc(1, 4, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 4, 32'hB, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 5'(i), i[0], 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 5, 32'h55, 1);
    cyc(1, 5, 0, 0, 0, 0, 0);
    cyc(1, 5, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    cyc(1, 5, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 1500; i++) begin
      a = 5'($urandom);
      cyc($urandom_range(0, 3) != 0, a, 1'($urandom), 1'($urandom),
          ($urandom % 2) ? a : 5'($urandom), $urandom, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 20 && (pend || q.size() != 0); i++) cyc(0, 0, 0, 0, 0, 0, 1);
    chk("drain_timeout", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
